// File: rtl/afifo_seq_checker.sv
// Read-side AFIFO consumer: drains words and checks that they form a strictly
// incrementing sequence (mod 2^Width). It reports the first mismatch, a count
// of popped words and a sticky stall watchdog.
module afifo_seq_checker #(
   parameter int unsigned Width      = 12,
   parameter int unsigned CountWidth = 32,
   parameter int unsigned StallLimit = 1024
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  en,
   output logic                  r,
   input  logic [Width-1:0]      rd,
   input  logic                  rempty,
   output logic                  ok,
   output logic                  fail,
   output logic                  stall,
   output logic [CountWidth-1:0] count,
   output logic [Width-1:0]      expected,
   output logic [Width-1:0]      got
);

   localparam int unsigned StallWidth = $clog2(StallLimit + 1);
   localparam logic [StallWidth-1:0] StallMax = StallWidth'(StallLimit);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRIME,
      S_RUN,
      S_FAIL
   } state_t;

   state_t                state, state_nxt;
   logic [Width-1:0]      next_val, next_val_nxt;
   logic [StallWidth-1:0] stall_cnt, stall_cnt_nxt;
   logic [CountWidth-1:0] count_nxt, count_inc;
   logic [Width-1:0]      expected_nxt, got_nxt;
   logic                  fail_nxt, stall_nxt, ok_nxt;
   logic                  active, pop;

   // Read strobe is combinational so that en=0 stops reads in the same cycle
   assign active = (state == S_PRIME) || (state == S_RUN);
   assign r      = en & active;
   assign pop    = r & ~rempty;

   // Saturating popped-word increment
   assign count_inc = (count == '1) ? count : count + CountWidth'(1);

   // Next-state, checker and watchdog logic
   always_comb begin
      state_nxt     = state;
      next_val_nxt  = next_val;
      stall_cnt_nxt = stall_cnt;
      count_nxt     = count;
      expected_nxt  = expected;
      got_nxt       = got;
      fail_nxt      = fail;
      stall_nxt     = stall;

      unique case (state)
         S_IDLE: begin
            if (en) state_nxt = S_PRIME;
         end
         S_PRIME: begin
            // Any starting value is accepted; it seeds the sequence
            if (pop) begin
               next_val_nxt = rd + Width'(1);
               count_nxt    = count_inc;
               state_nxt    = S_RUN;
            end
         end
         S_RUN: begin
            if (pop) begin
               count_nxt = count_inc;
               if (rd == next_val) begin
                  next_val_nxt = next_val + Width'(1);
               end else begin
                  expected_nxt = next_val;
                  got_nxt      = rd;
                  fail_nxt     = 1'b1;
                  state_nxt    = S_FAIL;
               end
            end
         end
         S_FAIL: begin
            state_nxt = S_FAIL;
         end
         default: state_nxt = S_IDLE;
      endcase

      // Watchdog counts starved read cycles; stall is sticky and never halts checking
      if (active) begin
         if (pop || !en) begin
            stall_cnt_nxt = '0;
         end else if (stall_cnt != StallMax) begin
            stall_cnt_nxt = stall_cnt + StallWidth'(1);
         end
         if (stall_cnt_nxt == StallMax) stall_nxt = 1'b1;
      end

      ok_nxt = (state_nxt == S_RUN) & ~fail_nxt;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= S_IDLE;
         next_val  <= '0;
         stall_cnt <= '0;
         count     <= '0;
         expected  <= '0;
         got       <= '0;
         fail      <= 1'b0;
         stall     <= 1'b0;
         ok        <= 1'b0;
      end else begin
         state     <= state_nxt;
         next_val  <= next_val_nxt;
         stall_cnt <= stall_cnt_nxt;
         count     <= count_nxt;
         expected  <= expected_nxt;
         got       <= got_nxt;
         fail      <= fail_nxt;
         stall     <= stall_nxt;
         ok        <= ok_nxt;
      end
   end

endmodule

// File: tb/tb_afifo_seq_checker.sv
// Scoreboard bench for afifo_seq_checker: stimulus drives one cycle at a time
// and queues the behavioural model's prediction; a monitor on the falling edge
// compares the strobe and post-edge outputs against the queue.
module tb_afifo_seq_checker;

   localparam int unsigned W  = 12;
   localparam int unsigned CW = 32;
   localparam int unsigned SL = 8;
   localparam int unsigned MODV = 1 << W;

   logic          clk = 1'b0;
   logic          rst_ = 1'b0;
   logic          en = 1'b0;
   logic          r;
   logic [W-1:0]  rd = '0;
   logic          rempty = 1'b1;
   logic          ok, fail, stall;
   logic [CW-1:0] count;
   logic [W-1:0]  expected, got;

   afifo_seq_checker #(.Width(W), .CountWidth(CW), .StallLimit(SL)) dut (
      .clk(clk), .rst_(rst_), .en(en), .r(r), .rd(rd), .rempty(rempty),
      .ok(ok), .fail(fail), .stall(stall), .count(count),
      .expected(expected), .got(got)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          r;
      bit          ok;
      bit          fail;
      bit          stall;
      longint      count;
      int unsigned exp_v;
      int unsigned got_v;
   } item_t;

   item_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 idle, 1 priming, 2 running, 3 failed
   int          m_phase;
   int unsigned m_next;
   longint      m_count;
   bit          m_fail, m_stall;
   int unsigned m_starve, m_exp, m_got;

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_next = 0; m_count = 0; m_fail = 0; m_stall = 0;
      m_starve = 0; m_exp = 0; m_got = 0;
   endtask

   // Drive one cycle, predict its effect, queue the prediction
   task automatic step(input bit e, input bit emp, input int unsigned d);
      item_t it;
      bit    pop;
      int    ph0;
      ph0    = m_phase;
      en     = e;
      rempty = emp;
      rd     = W'(d);
      it.r   = e && (ph0 == 1 || ph0 == 2);
      pop    = it.r && !emp;
      if (ph0 == 0 && e) begin
         m_phase = 1;
      end else if (pop) begin
         if (m_count < 64'hFFFF_FFFF) m_count++;
         if (ph0 == 1) begin
            m_next  = (d % MODV + 1) % MODV;
            m_phase = 2;
         end else if (d % MODV == m_next) begin
            m_next = (m_next + 1) % MODV;
         end else begin
            m_exp = m_next; m_got = d % MODV; m_fail = 1; m_phase = 3;
         end
      end
      if (ph0 == 1 || ph0 == 2) begin
         if (pop || !e) m_starve = 0;
         else if (m_starve < SL) m_starve++;
         if (m_starve == SL) m_stall = 1;
      end
      it.ok = (m_phase == 2) && !m_fail;
      it.fail = m_fail; it.stall = m_stall; it.count = m_count;
      it.exp_v = m_exp; it.got_v = m_got;
      q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_ = 1'b0; en = 1'b1; rempty = 1'b0; rd = W'($urandom);
      model_reset();
      #1;
      chk("rst_r", r, 0);        chk("rst_ok", ok, 0);
      chk("rst_fail", fail, 0);  chk("rst_stall", stall, 0);
      chk("rst_count", count, 0);
      chk("rst_expected", expected, 0);
      chk("rst_got", got, 0);
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b1;
   endtask

   // Monitor: post-edge outputs of the previous cycle, then this cycle's strobe
   item_t prev, cur;
   bit    have_prev = 0;
   always @(negedge clk) begin
      if (!rst_) begin
         have_prev = 0;
      end else begin
         if (have_prev) begin
            chk("ok", ok, prev.ok);
            chk("fail", fail, prev.fail);
            chk("stall", stall, prev.stall);
            chk("count", count, prev.count);
            chk("expected", expected, prev.exp_v);
            chk("got", got, prev.got_v);
         end
         if (q.size() > 0) begin
            cur = q.pop_front();
            chk("r", r, cur.r);
            prev = cur;
            have_prev = 1;
         end else begin
            have_prev = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      do_reset();
      step(1, 0, $urandom);                          // IDLE -> PRIME, no pop
      for (int i = 0; i < 6; i++) step(1, 0, i);     // clean run 0..5
      repeat (7) step(1, 1, $urandom);               // 7 starved edges
      step(1, 0, 6);                                 // pop clears watchdog
      repeat (8) step(1, 1, $urandom);               // stall asserts
      step(1, 0, 7);
      step(1, 0, 8);
      repeat (5) step(0, 0, $urandom);               // disabled: no pops
      step(1, 0, 9);                                 // resumes without reseed
      for (int i = 0; i < 300; i++) begin
         bit e, emp;
         e   = ($urandom_range(0, 9) != 0);
         emp = ($urandom_range(0, 3) == 0);
         step(e, emp, emp ? $urandom : m_next);
      end

      do_reset();                                    // wrap
      step(1, 0, $urandom);
      step(1, 0, 'hFFE); step(1, 0, 'hFFF); step(1, 0, 'h000); step(1, 0, 'h001);
      step(1, 0, 'h002);

      do_reset();                                    // reseed after reset
      step(1, 0, $urandom);
      step(1, 0, 'h100); step(1, 0, 'h101);

      do_reset();                                    // mismatch
      step(1, 0, $urandom);
      step(1, 0, 'h010); step(1, 0, 'h011); step(1, 0, 'h013);
      repeat (10) step(1, 0, $urandom);

      do_reset();                                    // random run with rare errors
      for (int i = 0; i < 400; i++) begin
         bit e, emp;
         int unsigned d;
         e   = ($urandom_range(0, 7) != 0);
         emp = ($urandom_range(0, 4) == 0);
         if (emp || m_phase != 2) d = $urandom;
         else if ($urandom_range(0, 99) == 0) d = m_next + $urandom_range(1, 5);
         else d = m_next;
         step(e, emp, d);
      end

      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
